// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit in front of the 8-byte, big-endian data
// memory (byte at addr sits in mem_rdata/mem_wdata[63:56]).
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   req_*           : one request at a time, accepted when req_valid && req_ready
//   resp_*          : one-cycle completion pulse with extended load data / fault
//   mem_*           : registered read/write strobes, address and write data
// Loads and sub-doubleword stores read the memory for one cycle; sub-doubleword
// stores then write back the merged doubleword. Requests whose 8-byte window
// would pass ADDR_MAX fault without touching memory.
module mem_lsu #(
  parameter logic [63:0] ADDR_MAX = 64'd255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // Highest legal start address for an 8-byte access.
  localparam logic [63:0] ADDR_LIM = ADDR_MAX - 64'd7;

  state_t      state;
  logic        r_we;
  logic        r_uns;
  logic [1:0]  r_size;
  logic [63:0] r_wdata;

  logic [63:0] load_val;
  logic [63:0] merge_val;

  // Load extraction: the addressed bytes are always the top of the doubleword.
  always_comb begin
    load_val = mem_rdata;
    case (r_size)
      2'b00: load_val = r_uns ? {56'd0, mem_rdata[63:56]}
                              : {{56{mem_rdata[63]}}, mem_rdata[63:56]};
      2'b01: load_val = r_uns ? {48'd0, mem_rdata[63:48]}
                              : {{48{mem_rdata[63]}}, mem_rdata[63:48]};
      2'b10: load_val = r_uns ? {32'd0, mem_rdata[63:32]}
                              : {{32{mem_rdata[63]}}, mem_rdata[63:32]};
      default: load_val = mem_rdata;
    endcase
  end

  // Store merge: new bytes replace the top of the doubleword just read.
  always_comb begin
    merge_val = r_wdata;
    case (r_size)
      2'b00: merge_val = {r_wdata[7:0],  mem_rdata[55:0]};
      2'b01: merge_val = {r_wdata[15:0], mem_rdata[47:0]};
      2'b10: merge_val = {r_wdata[31:0], mem_rdata[31:0]};
      default: merge_val = r_wdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_fault <= 1'b0;
      resp_rdata <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_size     <= '0;
      r_wdata    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            r_we      <= req_we;
            r_uns     <= req_unsigned;
            r_size    <= req_size;
            r_wdata   <= req_wdata;
            req_ready <= 1'b0;
            if (req_addr > ADDR_LIM) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
              resp_rdata <= '0;
            end else begin
              mem_addr <= req_addr;
              if (req_we && (req_size == 2'b11)) begin
                state     <= WR;
                mem_wr    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state  <= RD;
                mem_rd <= 1'b1;
              end
            end
          end
        end
        RD: begin
          mem_rd <= 1'b0;
          if (r_we) begin
            state     <= WR;
            mem_wr    <= 1'b1;
            mem_wdata <= merge_val;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_val;
          end
        end
        WR: begin
          mem_wr     <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [63:0] resp_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr;

  mem_lsu #(.ADDR_MAX(64'd255)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ---------------- data memory model ----------------
  logic [7:0] mem [256];
  logic       mem_loaded = 1'b0;

  function automatic logic [7:0] init_byte(input int a);
    if (a >= 'h10 && a <= 'h17) return (a == 'h10) ? 8'h80 : 8'(a - 'h10);
    if (a >= 'h30 && a <= 'h37) return 8'(8'hC0 + (a - 'h30));
    if (a == 'h40)              return 8'h3C;
    if (a >= 'hF8)              return 8'(8'hF0 + (a - 'hF8));
    return 8'h00;
  endfunction

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
      mem_loaded <= 1'b1;
    end else if (mem_wr && mem_addr <= 64'd248) begin
      for (int i = 0; i < 8; i++) mem[int'(mem_addr[7:0]) + i] <= mem_wdata[63-8*i -: 8];
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (mem_addr <= 64'd248)
      for (int i = 0; i < 8; i++) mem_rdata[63-8*i -: 8] = mem[int'(mem_addr[7:0]) + i];
  end

  function automatic logic [63:0] peek(input int a);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = mem[a + i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { logic [63:0] rdata; logic fault; } exp_t;
  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_fault", {63'd0, resp_fault}, {63'd0, e.fault});
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_fault;
    int          exp_lat;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] er, input logic ef, input int lat);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = er; v.exp_fault = ef; v.exp_lat = lat;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
  endtask

  function automatic exp_t to_exp(input vec_t v);
    exp_t e;
    e.rdata = v.exp_rdata; e.fault = v.exp_fault;
    return e;
  endfunction

  // Issue one request from a negedge and follow it to completion.
  task automatic issue(input vec_t v, input string nm);
    int k, lat, nrd, nwr, nrdy, erd, ewr;
    k = 0;
    while (!req_ready && k < 10) begin @(negedge clk); k++; end
    chk({nm, "_ready"}, {63'd0, req_ready}, 64'd1);
    exp_q.push_back(to_exp(v));
    drive(v);
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = '1;              // scramble: the unit must use its captured copy
    req_wdata = 64'h0BAD_0BAD_0BAD_0BAD;
    req_size  = ~v.size;
    req_we    = ~v.we;
    lat = 0; nrd = 0; nwr = 0; nrdy = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (req_ready) nrdy++;
      if (mem_rd) nrd++;
      if (mem_wr) nwr++;
      if (resp_valid) begin lat = c; break; end
    end
    if (v.exp_fault)             begin erd = 0; ewr = 0; end
    else if (!v.we)              begin erd = 1; ewr = 0; end
    else if (v.size == 2'b11)    begin erd = 0; ewr = 1; end
    else                         begin erd = 1; ewr = 1; end
    chk({nm, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, "_mem_rd_cycles"}, 64'(nrd), 64'(erd));
    chk({nm, "_mem_wr_cycles"}, 64'(nwr), 64'(ewr));
    chk({nm, "_ready_busy"}, 64'(nrdy), 64'd0);
    @(negedge clk);
    chk({nm, "_after_resp"}, {62'd0, resp_valid, req_ready}, 64'b01);
  endtask

  vec_t tbl[24];
  vec_t bb[3];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[3];
    int na, nwide, novl, nresp;
    logic prev_rv;
    logic accepted;

    //           we    size   uns   addr                    wdata                   exp_rdata               flt  lat
    tbl[0]  = mk(1'b0, 2'b00, 1'b0, 64'h10,                 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 2);
    tbl[1]  = mk(1'b0, 2'b00, 1'b1, 64'h10,                 64'h0,                  64'h80,                  1'b0, 2);
    tbl[2]  = mk(1'b0, 2'b01, 1'b0, 64'h10,                 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1'b0, 2);
    tbl[3]  = mk(1'b0, 2'b01, 1'b1, 64'h10,                 64'h0,                  64'h8001,                1'b0, 2);
    tbl[4]  = mk(1'b0, 2'b10, 1'b0, 64'h10,                 64'h0,                  64'hFFFF_FFFF_8001_0203, 1'b0, 2);
    tbl[5]  = mk(1'b0, 2'b10, 1'b1, 64'h11,                 64'h0,                  64'h0102_0304,           1'b0, 2);
    tbl[6]  = mk(1'b0, 2'b11, 1'b0, 64'h10,                 64'h0,                  64'h8001_0203_0405_0607, 1'b0, 2);
    tbl[7]  = mk(1'b0, 2'b11, 1'b1, 64'h10,                 64'h0,                  64'h8001_0203_0405_0607, 1'b0, 2);
    tbl[8]  = mk(1'b0, 2'b00, 1'b0, 64'h11,                 64'h0,                  64'h01,                  1'b0, 2);
    tbl[9]  = mk(1'b1, 2'b11, 1'b0, 64'h20,                 64'h1122_3344_5566_7788, 64'h0,                  1'b0, 2);
    tbl[10] = mk(1'b0, 2'b11, 1'b0, 64'h20,                 64'h0,                  64'h1122_3344_5566_7788, 1'b0, 2);
    tbl[11] = mk(1'b1, 2'b00, 1'b0, 64'h22,                 64'hFFFF_FFFF_FFFF_FFAB, 64'h0,                  1'b0, 3);
    tbl[12] = mk(1'b0, 2'b11, 1'b0, 64'h20,                 64'h0,                  64'h1122_AB44_5566_7788, 1'b0, 2);
    tbl[13] = mk(1'b1, 2'b10, 1'b0, 64'h30,                 64'h1234_5678_DEAD_BEEF, 64'h0,                  1'b0, 3);
    tbl[14] = mk(1'b0, 2'b11, 1'b0, 64'h30,                 64'h0,                  64'hDEAD_BEEF_C4C5_C6C7, 1'b0, 2);
    tbl[15] = mk(1'b1, 2'b01, 1'b0, 64'h31,                 64'hFFFF_0000_0000_5A5A, 64'h0,                  1'b0, 3);
    tbl[16] = mk(1'b0, 2'b10, 1'b1, 64'h30,                 64'h0,                  64'hDE5A_5AEF,           1'b0, 2);
    tbl[17] = mk(1'b0, 2'b11, 1'b0, 64'd248,                64'h0,                  64'hF0F1_F2F3_F4F5_F6F7, 1'b0, 2);
    tbl[18] = mk(1'b0, 2'b10, 1'b0, 64'd248,                64'h0,                  64'hFFFF_FFFF_F0F1_F2F3, 1'b0, 2);
    tbl[19] = mk(1'b0, 2'b00, 1'b1, 64'd249,                64'h0,                  64'h0,                   1'b1, 1);
    tbl[20] = mk(1'b1, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1234,              64'h0,                   1'b1, 1);
    tbl[21] = mk(1'b0, 2'b11, 1'b0, 64'h8000_0000_0000_0000, 64'h0,                 64'h0,                   1'b1, 1);
    tbl[22] = mk(1'b1, 2'b00, 1'b0, 64'd249,                64'h77,                 64'h0,                   1'b1, 1);
    tbl[23] = mk(1'b0, 2'b01, 1'b0, 64'd255,                64'h0,                  64'h0,                   1'b1, 1);

    rst_n = 1'b0; req_valid = 1'b0;
    drive(mk(1'b0, 2'b00, 1'b0, 64'h0, 64'h0, 64'h0, 1'b0, 0));
    @(negedge clk); @(negedge clk);
    chk("reset_ctl", {59'd0, req_ready, resp_valid, resp_fault, mem_rd, mem_wr}, 64'b10000);
    chk("reset_rdata", resp_rdata, 64'h0);
    chk("reset_mem_addr", mem_addr, 64'h0);
    chk("reset_mem_wdata", mem_wdata, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 24; i++) issue(tbl[i], $sformatf("vec%0d", i));

    chk("mem_0x20", peek('h20), 64'h1122_AB44_5566_7788);
    chk("mem_0x30", peek('h30), 64'hDE5A_5AEF_C4C5_C6C7);

    // Back-to-back: req_valid held high across three loads.
    bb[0] = mk(1'b0, 2'b00, 1'b1, 64'h10,  64'h0, 64'h80,                  1'b0, 2);
    bb[1] = mk(1'b0, 2'b11, 1'b0, 64'h20,  64'h0, 64'h1122_AB44_5566_7788, 1'b0, 2);
    bb[2] = mk(1'b0, 2'b11, 1'b0, 64'd248, 64'h0, 64'hF0F1_F2F3_F4F5_F6F7, 1'b0, 2);
    na = 0; nwide = 0; novl = 0; nresp = 0; prev_rv = 1'b0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    drive(bb[0]);
    req_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (resp_valid && prev_rv) nwide++;
      if (resp_valid && !prev_rv) nresp++;
      if (resp_valid && req_ready) novl++;
      prev_rv = resp_valid;
      accepted = 1'b0;
      if (req_valid && req_ready && na < 3) begin
        acc[na] = c;
        exp_q.push_back(to_exp(bb[na]));
        na++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
      if (accepted) begin
        if (na < 3) drive(bb[na]);
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_accepts", 64'(na), 64'd3);
    chk("b2b_spacing01", 64'(acc[1] - acc[0]), 64'd3);
    chk("b2b_spacing12", 64'(acc[2] - acc[1]), 64'd3);
    chk("b2b_resp_count", 64'(nresp), 64'd3);
    chk("b2b_resp_width", 64'(nwide), 64'd0);
    chk("b2b_ready_in_resp", 64'(novl), 64'd0);

    // Reset in the WR cycle of a sub-doubleword store, before the falling edge.
    drive(mk(1'b1, 2'b00, 1'b0, 64'h40, 64'h55, 64'h0, 1'b0, 0));
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_seq_rd", {63'd0, mem_rd}, 64'd1);
    @(posedge clk); #1;
    chk("rst_seq_wr", {63'd0, mem_wr}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_ctl", {59'd0, req_ready, resp_valid, resp_fault, mem_rd, mem_wr}, 64'b10000);
    chk("midrst_rdata", resp_rdata, 64'h0);
    chk("midrst_mem_addr", mem_addr, 64'h0);
    chk("midrst_mem_wdata", mem_wdata, 64'h0);
    @(negedge clk); @(negedge clk);
    chk("midrst_mem_0x40", {56'd0, mem['h40]}, 64'h3C);
    rst_n = 1'b1;
    issue(mk(1'b0, 2'b00, 1'b1, 64'h40, 64'h0, 64'h3C, 1'b0, 2), "post_reset_load");

    @(negedge clk); @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
